// File: rtl/cp0_pkg.sv
// Shared definitions for the coprocessor-0 block.
// Holds the CP0 register numbers, the SR/Cause field positions, the
// architectural state record passed from the register file to the top,
// and helpers that pack that state into the 32-bit read images.
package cp0_pkg;

    localparam int HWINT_W = 6;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam int IM_HI   = 15;
    localparam int IM_LO   = 10;
    localparam int EXL_BIT = 1;
    localparam int IE_BIT  = 0;

    // Architectural CP0 state as seen by the read mux and interrupt logic.
    typedef struct packed {
        logic [HWINT_W-1:0] im;
        logic               exl;
        logic               ie;
        logic [HWINT_W-1:0] ip;
        logic [29:0]        epc;
    } cp0_state_t;

    function automatic logic [31:0] sr_image(input cp0_state_t s);
        logic [31:0] r;
        r              = '0;
        r[IM_HI:IM_LO] = s.im;
        r[EXL_BIT]     = s.exl;
        r[IE_BIT]      = s.ie;
        return r;
    endfunction

    function automatic logic [31:0] cause_image(input cp0_state_t s);
        logic [31:0] r;
        r              = '0;
        r[IM_HI:IM_LO] = s.ip;
        return r;
    endfunction

endpackage

// File: rtl/cp0_unit_if.sv
// Pipeline <-> CP0 connection bundle.
//   a1      : register number for mfc0 reads
//   a2      : register number for mtc0 writes
//   din     : mtc0 write data, we : write enable
//   pc      : PC[31:2] of the instruction being interrupted
//   exl_set : interrupt accepted this cycle, exl_clr : eret this cycle
//   hwint   : level-sensitive hardware interrupt lines ([2]/[3] are the timers)
//   intreq  : interrupt request back to pipeline control
//   epc     : EPC[31:2] (eret target), dout : mfc0 read data
// The pipeline side uses modport master, the coprocessor uses modport slave.
interface cp0_unit_if;
    import cp0_pkg::*;

    logic [4:0]         a1;
    logic [4:0]         a2;
    logic [31:0]        din;
    logic               we;
    logic [29:0]        pc;
    logic               exl_set;
    logic               exl_clr;
    logic [HWINT_W-1:0] hwint;
    logic               intreq;
    logic [29:0]        epc;
    logic [31:0]        dout;

    modport master (
        output a1, a2, din, we, pc, exl_set, exl_clr, hwint,
        input  intreq, epc, dout
    );

    modport slave (
        input  a1, a2, din, we, pc, exl_set, exl_clr, hwint,
        output intreq, epc, dout
    );

endinterface

// File: rtl/cp0_regfile.sv
// SR / Cause / EPC storage with the write-priority logic.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   we_i, a2_i, din_i : mtc0 write port
//   pc_i         : PC[31:2] saved into EPC when an interrupt is taken
//   exl_set_i    : interrupt taken (set EXL, save PC)
//   exl_clr_i    : eret (clear EXL)
//   hwint_i      : raw interrupt lines, captured into Cause.IP every cycle
//   state_o      : current register state
// Precedence for a single edge: reset, exl_set, exl_clr, mtc0.
module cp0_regfile
    import cp0_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               we_i,
    input  logic [4:0]         a2_i,
    input  logic [31:0]        din_i,
    input  logic [29:0]        pc_i,
    input  logic               exl_set_i,
    input  logic               exl_clr_i,
    input  logic [HWINT_W-1:0] hwint_i,
    output cp0_state_t         state_o
);

    logic [HWINT_W-1:0] im_q, im_d;
    logic               exl_q, exl_d;
    logic               ie_q, ie_d;
    logic [HWINT_W-1:0] ip_q, ip_d;
    logic [29:0]        epc_q, epc_d;

    logic sr_wr;
    logic epc_wr;

    assign sr_wr  = we_i && (a2_i == CP0_SR);
    assign epc_wr = we_i && (a2_i == CP0_EPC);

    always_comb begin
        im_d  = im_q;
        ie_d  = ie_q;
        exl_d = exl_q;
        epc_d = epc_q;
        ip_d  = hwint_i;

        // Lowest priority first; later assignments override.
        // IM/IE are only ever written by mtc0, so they take din even when
        // exl_set/exl_clr coincide; only EXL and EPC are contested.
        if (sr_wr) begin
            im_d  = din_i[IM_HI:IM_LO];
            ie_d  = din_i[IE_BIT];
            exl_d = din_i[EXL_BIT];
        end
        if (epc_wr) begin
            epc_d = din_i[31:2];
        end
        if (exl_clr_i) begin
            exl_d = 1'b0;
        end
        if (exl_set_i) begin
            exl_d = 1'b1;
            epc_d = pc_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            im_q  <= '0;
            ie_q  <= 1'b0;
            exl_q <= 1'b0;
            ip_q  <= '0;
            epc_q <= '0;
        end else begin
            im_q  <= im_d;
            ie_q  <= ie_d;
            exl_q <= exl_d;
            ip_q  <= ip_d;
            epc_q <= epc_d;
        end
    end

    always_comb begin
        state_o     = '0;
        state_o.im  = im_q;
        state_o.exl = exl_q;
        state_o.ie  = ie_q;
        state_o.ip  = ip_q;
        state_o.epc = epc_q;
    end

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0 for the pipelined MIPS core, placed beside the M stage.
// Masks the hardware interrupt lines, raises intreq, keeps EPC and serves
// mfc0/mtc0 for SR(12), Cause(13), EPC(14) and PrID(15).
// Ports:
//   clk_i : clock, rst_i : synchronous active-high reset
//   bus   : cp0_unit_if slave modport (read/write port, interrupt control,
//           hwint inputs, intreq/epc/dout outputs)
// Reads are combinational with no write bypass: a same-cycle mtc0 to the
// register being read shows up only from the next cycle.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID = 32'h0000_2023
) (
    input  logic       clk_i,
    input  logic       rst_i,
    cp0_unit_if.slave  bus
);

    cp0_state_t  state;
    logic [31:0] rdata;

    cp0_regfile u_regfile (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .we_i      (bus.we),
        .a2_i      (bus.a2),
        .din_i     (bus.din),
        .pc_i      (bus.pc),
        .exl_set_i (bus.exl_set),
        .exl_clr_i (bus.exl_clr),
        .hwint_i   (bus.hwint),
        .state_o   (state)
    );

    // Uses raw hwint rather than the registered IP copy so a newly raised
    // line is seen by the pipeline in the same cycle.
    assign bus.intreq = (|(bus.hwint & state.im)) & state.ie & ~state.exl;

    assign bus.epc = state.epc;

    always_comb begin
        rdata = '0;
        case (bus.a1)
            CP0_SR:    rdata = sr_image(state);
            CP0_CAUSE: rdata = cause_image(state);
            CP0_EPC:   rdata = {state.epc, 2'b00};
            CP0_PRID:  rdata = PRID;
            default:   rdata = '0;
        endcase
    end

    assign bus.dout = rdata;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit. The stimulus process drives one cycle at a
// time and queues the values expected during that cycle; a monitor on the
// falling edge pops and compares them against the DUT outputs.
module tb_cp0_unit;
    import cp0_pkg::*;

    logic clk;
    logic rst;

    cp0_unit_if bus ();

    cp0_unit #(.PRID(32'h0000_2023)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;   // 0: dout, 1: intreq, 2: epc
        logic [31:0] exp;
    } chk_t;

    chk_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            chk_t        c;
            logic [31:0] act;
            c = sb.pop_front();
            case (c.sel)
                0:       act = bus.dout;
                1:       act = {31'b0, bus.intreq};
                default: act = {2'b00, bus.epc};
            endcase
            n_checks++;
            if (act !== c.exp) begin
                n_errors++;
                $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
            end
        end
    end

    task automatic push(input string n, input int s, input logic [31:0] e);
        chk_t c;
        c.name = n;
        c.sel  = s;
        c.exp  = e;
        sb.push_back(c);
    endtask

    task automatic rd(input string n, input logic [4:0] a, input logic [31:0] e);
        bus.a1 = a;
        push(n, 0, e);
    endtask

    task automatic irq(input string n, input logic e);
        push(n, 1, {31'b0, e});
    endtask

    task automatic epcchk(input string n, input logic [29:0] e);
        push(n, 2, {2'b00, e});
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.we  = 1'b1;
        bus.a2  = a;
        bus.din = d;
    endtask

    // Advance to just after the next rising edge and clear one-shot controls.
    task automatic cyc();
        @(posedge clk);
        #1;
        bus.we      = 1'b0;
        bus.exl_set = 1'b0;
        bus.exl_clr = 1'b0;
    endtask

    initial begin
        int waited;
        rst         = 1'b1;
        bus.a1      = '0;
        bus.a2      = '0;
        bus.din     = '0;
        bus.we      = 1'b0;
        bus.pc      = '0;
        bus.exl_set = 1'b0;
        bus.exl_clr = 1'b0;
        bus.hwint   = '0;
        cyc();
        cyc();
        rst = 1'b0;

        // Reset state
        rd("rst_sr", CP0_SR, 32'h0); irq("rst_intreq", 1'b0); epcchk("rst_epc", 30'h0);
        cyc();
        rd("rst_cause", CP0_CAUSE, 32'h0); cyc();
        rd("rst_epcrd", CP0_EPC, 32'h0); cyc();
        rd("rst_prid", CP0_PRID, 32'h0000_2023); cyc();

        // SR write, same-cycle read returns old value
        wr(CP0_SR, 32'h0000_0401); bus.hwint = 6'b000001;
        rd("sr_nobypass", CP0_SR, 32'h0); irq("irq_before_sr", 1'b0); cyc();
        rd("cause_lag", CP0_CAUSE, 32'h0000_0400); irq("irq_on", 1'b1); cyc();
        bus.hwint = 6'b0;
        rd("cause_lag_hold", CP0_CAUSE, 32'h0000_0400); irq("irq_raw_drop", 1'b0); cyc();
        bus.hwint = 6'b000001;
        rd("cause_lag_clear", CP0_CAUSE, 32'h0); irq("irq_raw_rise", 1'b1); cyc();

        // Interrupt taken
        bus.exl_set = 1'b1; bus.pc = 30'h0000_0C01;
        rd("sr_pre_exl", CP0_SR, 32'h0000_0401); irq("irq_accept", 1'b1); cyc();
        rd("epc_saved", CP0_EPC, 32'h0000_3004); irq("irq_exl", 1'b0); epcchk("epc_out", 30'h0000_0C01); cyc();
        rd("sr_exl", CP0_SR, 32'h0000_0403); cyc();

        // eret with source still active, then with source gone
        bus.exl_clr = 1'b1; irq("irq_during_eret", 1'b0); cyc();
        irq("irq_reassert", 1'b1); rd("sr_after_eret", CP0_SR, 32'h0000_0401);
        bus.exl_set = 1'b1; bus.pc = 30'h20; cyc();
        bus.exl_clr = 1'b1; bus.hwint = 6'b0; irq("irq_eret_quiet", 1'b0); cyc();
        irq("irq_stays_low", 1'b0); rd("sr_quiet", CP0_SR, 32'h0000_0401); cyc();

        // exl_set + mtc0 EPC: write lost
        bus.exl_set = 1'b1; bus.pc = 30'h10; wr(CP0_EPC, 32'hFFFF_FFFC);
        rd("epc_old", CP0_EPC, 32'h0000_0080); cyc();
        rd("epc_set_wins", CP0_EPC, 32'h0000_0040); epcchk("epc_set_wins_o", 30'h10); cyc();

        // exl_clr + mtc0 SR: exl ends 0, im/ie from din
        bus.exl_clr = 1'b1; wr(CP0_SR, 32'h0000_0403);
        rd("sr_clr_old", CP0_SR, 32'h0000_0403); cyc();
        rd("sr_clr_wins", CP0_SR, 32'h0000_0401);
        bus.exl_set = 1'b1; bus.exl_clr = 1'b1; bus.pc = 30'h55; cyc();
        rd("sr_set_clr", CP0_SR, 32'h0000_0403); epcchk("epc_set_clr", 30'h55);
        bus.exl_set = 1'b1; bus.pc = 30'h66; wr(CP0_SR, 32'h0000_0800); cyc();
        rd("sr_set_mtc0", CP0_SR, 32'h0000_0802); epcchk("epc_set_mtc0", 30'h66);
        bus.exl_clr = 1'b1; wr(CP0_SR, 32'hFFFF_FFFF); cyc();

        // Read-only fields, ignored writes, plain EPC write
        rd("sr_ro_bits", CP0_SR, 32'h0000_FC01); irq("irq_no_lines", 1'b0);
        wr(CP0_CAUSE, 32'hFFFF_FFFF); cyc();
        rd("cause_wr_ignored", CP0_CAUSE, 32'h0); wr(CP0_PRID, 32'h0); cyc();
        rd("prid_wr_ignored", CP0_PRID, 32'h0000_2023); wr(CP0_EPC, 32'h1234_5677); cyc();
        rd("epc_mtc0", CP0_EPC, 32'h1234_5674); epcchk("epc_mtc0_o", 30'h048D_159D);
        wr(CP0_SR, 32'h0000_0802); cyc();
        rd("sr_exl_by_mtc0", CP0_SR, 32'h0000_0802); wr(CP0_SR, 32'h0000_0801); cyc();

        // Masking
        bus.hwint = 6'b000001;
        irq("irq_masked", 1'b0); rd("sr_mask", CP0_SR, 32'h0000_0801); cyc();
        bus.hwint = 6'b000010;
        irq("irq_mask_match", 1'b1); rd("cause_bit10", CP0_CAUSE, 32'h0000_0400);
        wr(CP0_SR, 32'h0000_0400); cyc();
        bus.hwint = 6'b000001;
        irq("irq_ie_off", 1'b0); rd("sr_ie_off", CP0_SR, 32'h0000_0400);
        wr(CP0_SR, 32'h0000_0401); cyc();
        bus.exl_set = 1'b1; bus.pc = 30'h3FFF_FFFF; irq("irq_pre_rst", 1'b1); cyc();

        // Reset mid-EXL
        rst = 1'b1; bus.hwint = 6'b111111;
        rd("sr_pre_rst", CP0_SR, 32'h0000_0403); irq("irq_in_exl", 1'b0);
        epcchk("epc_pre_rst", 30'h3FFF_FFFF); cyc();
        rst = 1'b0;
        rd("cause_post_rst", CP0_CAUSE, 32'h0); irq("irq_post_rst", 1'b0);
        epcchk("epc_post_rst", 30'h0); cyc();
        rd("sr_post_rst", CP0_SR, 32'h0); cyc();
        rd("cause_all_lines", CP0_CAUSE, 32'h0000_FC00); cyc();
        rd("epcrd_post_rst", CP0_EPC, 32'h0); cyc();

        waited = 0;
        while (sb.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d checks left pending, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
